uart_pkt_deframer: RTL and testbench

- Consumes the byte stream from the UART receiver (one-cycle data-valid pulse plus byte) and deframes command packets: SYNC, LEN, LEN payload bytes, CHK.
- Stores the payload in an internal buffer and validates the length and checksum.
- Presents a complete, good packet to the command decoder through a level-valid/ack handshake and a registered read port.
- Reports malformed packets as one-cycle error pulses.

---
 rtl/uart_pkt_defs_pkg.sv | 24 ++
 rtl/uart_pkt_buffer.sv | 40 ++++
 rtl/uart_pkt_deframer.sv | 190 +++++++++++++++++++
 tb/tb_uart_pkt_deframer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkt_defs_pkg.sv
// Shared definitions for the UART packet deframer: state encodings, default
// start-of-packet marker and the checksum acceptance rule.
package uart_pkt_defs_pkg;

    typedef enum logic [2:0] {
        HUNT    = 3'd0,
        LEN     = 3'd1,
        PAYLOAD = 3'd2,
        CHK     = 3'd3,
        HOLD    = 3'd4
    } state_e;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    // LEN + payload + CHK must sum to this value modulo 256.
    localparam logic [7:0] CHK_RESIDUE = 8'h00;

    function automatic logic chk_ok(input logic [7:0] sum, input logic [7:0] chk_byte);
        logic [7:0] total;
        total = sum + chk_byte;
        return total == CHK_RESIDUE;
    endfunction

endpackage

// File: rtl/uart_pkt_buffer.sv
// Payload register file for the packet deframer: one synchronous write port
// and one registered read port. Storage is not reset; read data resets to 0.
module uart_pkt_buffer #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_Clock,
    input  logic          i_Rst_L,
    input  logic          i_Wr_En,
    input  logic [AW-1:0] i_Wr_Addr,
    input  logic [7:0]    i_Wr_Data,
    input  logic [AW-1:0] i_Rd_Addr,
    output logic [7:0]    o_Rd_Data
);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] rd_data_d;
    logic [7:0] rd_data_q;

    always_ff @(posedge i_Clock) begin
        if (i_Wr_En) begin
            mem_q[i_Wr_Addr] <= i_Wr_Data;
        end
    end

    always_comb begin
        rd_data_d = mem_q[i_Rd_Addr];
    end

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            rd_data_q <= 8'd0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign o_Rd_Data = rd_data_q;

endmodule

// File: rtl/uart_pkt_deframer.sv
// Deframes SYNC/LEN/payload/CHK packets from a UART byte stream and holds a good
// packet for the command decoder. Define UART_PKT_TIMEOUT_EN for the idle abort.
module uart_pkt_deframer
    import uart_pkt_defs_pkg::*;
#(
    parameter int         MAX_LEN      = 16,
    parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE,
    parameter int         TIMEOUT_CLKS = 21700
) (
    input  logic                         i_Clock,
    input  logic                         i_Rst_L,
    input  logic                         i_RX_DV,
    input  logic [7:0]                   i_RX_Byte,
    output logic                         o_Pkt_Valid,
    output logic [$clog2(MAX_LEN+1)-1:0] o_Pkt_Len,
    input  logic                         i_Pkt_Ack,
    input  logic [$clog2(MAX_LEN)-1:0]   i_Rd_Addr,
    output logic [7:0]                   o_Rd_Data,
    output logic                         o_Busy,
    output logic                         o_Err_Chk,
    output logic                         o_Err_Len,
    output logic                         o_Overrun
`ifdef UART_PKT_TIMEOUT_EN
    ,
    output logic                         o_Err_Timeout
`endif
);

    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int AW = $clog2(MAX_LEN);

    state_e          state_q, state_d;
    logic [LW-1:0]   len_q, len_d;
    logic [LW-1:0]   idx_q, idx_d;
    logic [7:0]      sum_q, sum_d;
    logic            pkt_valid_q, pkt_valid_d;
    logic [LW-1:0]   pkt_len_q, pkt_len_d;
    logic            err_chk_q, err_chk_d;
    logic            err_len_q, err_len_d;
    logic            overrun_q, overrun_d;
    logic            wr_en;
    logic            rx_sync;

    assign rx_sync = i_RX_DV && (i_RX_Byte == SYNC_BYTE);

`ifdef UART_PKT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CLKS);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);

    logic [TW-1:0]   tmo_q, tmo_d;
    logic            err_tmo_q, err_tmo_d;
`endif

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        idx_d       = idx_q;
        sum_d       = sum_q;
        pkt_valid_d = pkt_valid_q;
        pkt_len_d   = pkt_len_q;
        err_chk_d   = 1'b0;
        err_len_d   = 1'b0;
        overrun_d   = 1'b0;
        wr_en       = 1'b0;

        case (state_q)
            HUNT: begin
                if (rx_sync) state_d = LEN;
            end
            LEN: begin
                if (i_RX_DV) begin
                    len_d = i_RX_Byte[LW-1:0];
                    sum_d = i_RX_Byte;
                    if (i_RX_Byte > 8'(MAX_LEN)) begin
                        err_len_d = 1'b1;
                        state_d   = HUNT;
                    end else if (i_RX_Byte == 8'd0) begin
                        state_d = CHK;
                    end else begin
                        idx_d   = '0;
                        state_d = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (i_RX_DV) begin
                    wr_en = 1'b1;
                    sum_d = sum_q + i_RX_Byte;
                    idx_d = idx_q + 1'b1;
                    if (idx_q == len_q - 1'b1) state_d = CHK;
                end
            end
            CHK: begin
                if (i_RX_DV) begin
                    if (chk_ok(sum_q, i_RX_Byte)) begin
                        pkt_valid_d = 1'b1;
                        pkt_len_d   = len_q;
                        state_d     = HOLD;
                    end else begin
                        err_chk_d = 1'b1;
                        state_d   = HUNT;
                    end
                end
            end
            HOLD: begin
                // An ack releases the packet; a coincident byte is judged as a hunt byte.
                if (i_Pkt_Ack) begin
                    pkt_valid_d = 1'b0;
                    pkt_len_d   = '0;
                    state_d     = rx_sync ? LEN : HUNT;
                end else if (i_RX_DV) begin
                    overrun_d = 1'b1;
                end
            end
            default: state_d = HUNT;
        endcase

`ifdef UART_PKT_TIMEOUT_EN
        tmo_d     = '0;
        err_tmo_d = 1'b0;
        if ((state_q == LEN || state_q == PAYLOAD || state_q == CHK) && !i_RX_DV) begin
            if (tmo_q == TMO_LAST) begin
                err_tmo_d = 1'b1;
                state_d   = HUNT;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q     <= HUNT;
            len_q       <= '0;
            idx_q       <= '0;
            sum_q       <= 8'd0;
            pkt_valid_q <= 1'b0;
            pkt_len_q   <= '0;
            err_chk_q   <= 1'b0;
            err_len_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            sum_q       <= sum_d;
            pkt_valid_q <= pkt_valid_d;
            pkt_len_q   <= pkt_len_d;
            err_chk_q   <= err_chk_d;
            err_len_q   <= err_len_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef UART_PKT_TIMEOUT_EN
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            tmo_q     <= '0;
            err_tmo_q <= 1'b0;
        end else begin
            tmo_q     <= tmo_d;
            err_tmo_q <= err_tmo_d;
        end
    end

    assign o_Err_Timeout = err_tmo_q;
`endif

    uart_pkt_buffer #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_buffer (
        .i_Clock   (i_Clock),
        .i_Rst_L   (i_Rst_L),
        .i_Wr_En   (wr_en),
        .i_Wr_Addr (idx_q[AW-1:0]),
        .i_Wr_Data (i_RX_Byte),
        .i_Rd_Addr (i_Rd_Addr),
        .o_Rd_Data (o_Rd_Data)
    );

    assign o_Pkt_Valid = pkt_valid_q;
    assign o_Pkt_Len   = pkt_len_q;
    assign o_Busy      = (state_q == LEN) || (state_q == PAYLOAD) || (state_q == CHK);
    assign o_Err_Chk   = err_chk_q;
    assign o_Err_Len   = err_len_q;
    assign o_Overrun   = overrun_q;

endmodule

// File: tb/tb_uart_pkt_deframer.sv
// Directed-vector bench for uart_pkt_deframer: a per-cycle table of inputs and
// expected outputs, plus hand sequences for reset, max length and timeout.
module tb_uart_pkt_deframer;

`ifdef UART_PKT_TIMEOUT_EN
    localparam int TMO = 50;
`else
    localparam int TMO = 21700;
`endif

    logic       clk = 1'b0;
    logic       rst_l = 1'b0;
    logic       rx_dv = 1'b0;
    logic [7:0] rx_byte = 8'd0;
    logic       ack = 1'b0;
    logic [3:0] rd_addr = 4'd0;
    logic       pkt_valid;
    logic [4:0] pkt_len;
    logic [7:0] rd_data;
    logic       busy, err_chk, err_len, overrun;
`ifdef UART_PKT_TIMEOUT_EN
    logic       err_tmo;
`endif

    int checks = 0;
    int errors = 0;

    uart_pkt_deframer #(
        .MAX_LEN      (16),
        .SYNC_BYTE    (8'hA5),
        .TIMEOUT_CLKS (TMO)
    ) dut (
        .i_Clock     (clk),
        .i_Rst_L     (rst_l),
        .i_RX_DV     (rx_dv),
        .i_RX_Byte   (rx_byte),
        .o_Pkt_Valid (pkt_valid),
        .o_Pkt_Len   (pkt_len),
        .i_Pkt_Ack   (ack),
        .i_Rd_Addr   (rd_addr),
        .o_Rd_Data   (rd_data),
        .o_Busy      (busy),
        .o_Err_Chk   (err_chk),
        .o_Err_Len   (err_len),
        .o_Overrun   (overrun)
`ifdef UART_PKT_TIMEOUT_EN
        ,
        .o_Err_Timeout (err_tmo)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       dv;
        bit [7:0] b;
        bit       ack;
        bit [3:0] ra;
        bit       crd;
        bit [7:0] erd;
        bit       ev;
        bit [4:0] el;
        bit       eb;
        bit       ec;
        bit       ee;
        bit       eo;
    } vec_t;

    vec_t vq[$];

    task automatic add(input bit dv, input bit [7:0] b, input bit a, input bit [3:0] ra,
                       input bit crd, input bit [7:0] erd, input bit ev, input bit [4:0] el,
                       input bit eb, input bit ec, input bit ee, input bit eo);
        vec_t v;
        v.dv = dv; v.b = b; v.ack = a; v.ra = ra; v.crd = crd; v.erd = erd;
        v.ev = ev; v.el = el; v.eb = eb; v.ec = ec; v.ee = ee; v.eo = eo;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs from the falling edge; sample 1ns after the rising edge.
    task automatic step(input bit dv, input bit [7:0] b, input bit a, input bit [3:0] ra);
        @(negedge clk);
        rx_dv = dv; rx_byte = b; ack = a; rd_addr = ra;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_valid"}, int'(pkt_valid), 0);
        chk({tag, "_len"},   int'(pkt_len),   0);
        chk({tag, "_busy"},  int'(busy),      0);
        chk({tag, "_echk"},  int'(err_chk),   0);
        chk({tag, "_elen"},  int'(err_len),   0);
        chk({tag, "_ovr"},   int'(overrun),   0);
    endtask

    initial begin
        // Good packet: 03+11+22+33 = 69, so 97 brings the sum to 00.
        add(1,8'hA5,0,0, 0,0, 0,0,1,0,0,0);
        add(1,8'h03,0,0, 0,0, 0,0,1,0,0,0);
        add(1,8'h11,0,0, 0,0, 0,0,1,0,0,0);
        add(1,8'h22,0,0, 0,0, 0,0,1,0,0,0);
        add(1,8'h33,0,0, 0,0, 0,0,1,0,0,0);
        add(1,8'h97,0,0, 0,0, 1,3,0,0,0,0);
        add(0,8'h00,0,0, 1,8'h11, 1,3,0,0,0,0);
        add(0,8'h00,0,1, 1,8'h22, 1,3,0,0,0,0);
        add(0,8'h00,0,2, 1,8'h33, 1,3,0,0,0,0);
        add(1,8'h55,0,0, 0,0, 1,3,0,0,0,1);
        add(0,8'h00,0,0, 1,8'h11, 1,3,0,0,0,0);
        add(0,8'h00,1,0, 0,0, 0,0,0,0,0,0);
        // Bad checksum, then an ack outside HOLD
        add(1,8'hA5,0,0, 0,0, 0,0,1,0,0,0);
        add(1,8'h02,0,0, 0,0, 0,0,1,0,0,0);
        add(1,8'h10,0,0, 0,0, 0,0,1,0,0,0);
        add(1,8'h20,0,0, 0,0, 0,0,1,0,0,0);
        add(1,8'h00,0,0, 0,0, 0,0,0,1,0,0);
        add(0,8'h00,1,0, 0,0, 0,0,0,0,0,0);
        // Length too large
        add(1,8'hA5,0,0, 0,0, 0,0,1,0,0,0);
        add(1,8'h11,0,0, 0,0, 0,0,0,0,1,0);
        add(0,8'h00,0,0, 0,0, 0,0,0,0,0,0);
        // Zero-length packet
        add(1,8'hA5,0,0, 0,0, 0,0,1,0,0,0);
        add(1,8'h00,0,0, 0,0, 0,0,1,0,0,0);
        add(1,8'h00,0,0, 0,0, 1,0,0,0,0,0);
        // Ack together with a SYNC byte, then 01,7F,80
        add(1,8'hA5,1,0, 0,0, 0,0,1,0,0,0);
        add(1,8'h01,0,0, 0,0, 0,0,1,0,0,0);
        add(1,8'h7F,0,0, 0,0, 0,0,1,0,0,0);
        add(1,8'h80,0,0, 0,0, 1,1,0,0,0,0);
        add(0,8'h00,0,0, 1,8'h7F, 1,1,0,0,0,0);
        add(0,8'h00,1,0, 0,0, 0,0,0,0,0,0);
        // SYNC value as payload and checksum-path data: 02+A5+A5 = 4C, B4 closes it
        add(1,8'hA5,0,0, 0,0, 0,0,1,0,0,0);
        add(1,8'h02,0,0, 0,0, 0,0,1,0,0,0);
        add(1,8'hA5,0,0, 0,0, 0,0,1,0,0,0);
        add(1,8'hA5,0,0, 0,0, 0,0,1,0,0,0);
        add(1,8'hB4,0,0, 0,0, 1,2,0,0,0,0);
        add(0,8'h00,0,1, 1,8'hA5, 1,2,0,0,0,0);
        add(0,8'h00,1,0, 0,0, 0,0,0,0,0,0);

        // Reset state
        #1;
        chk_idle_outputs("reset");
        chk("reset_rd", int'(rd_data), 0);
        repeat (2) @(negedge clk);
        rst_l = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].dv, vq[i].b, vq[i].ack, vq[i].ra);
            chk($sformatf("v%0d_valid", i), int'(pkt_valid), int'(vq[i].ev));
            chk($sformatf("v%0d_len", i),   int'(pkt_len),   int'(vq[i].el));
            chk($sformatf("v%0d_busy", i),  int'(busy),      int'(vq[i].eb));
            chk($sformatf("v%0d_echk", i),  int'(err_chk),   int'(vq[i].ec));
            chk($sformatf("v%0d_elen", i),  int'(err_len),   int'(vq[i].ee));
            chk($sformatf("v%0d_ovr", i),   int'(overrun),   int'(vq[i].eo));
            if (vq[i].crd) chk($sformatf("v%0d_rd", i), int'(rd_data), int'(vq[i].erd));
        end

        // Maximum length: 16 bytes 00..0F; 10 + 78 = 88, so 78 closes it
        step(1, 8'hA5, 0, 0);
        step(1, 8'h10, 0, 0);
        for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0);
        chk("max_busy_chk", int'(busy), 1);
        step(1, 8'h78, 0, 0);
        chk("max_valid", int'(pkt_valid), 1);
        chk("max_len", int'(pkt_len), 16);
        step(0, 8'h00, 0, 4'd15);
        chk("max_rd15", int'(rd_data), 8'h0F);
        step(0, 8'h00, 0, 4'd9);
        chk("max_rd9", int'(rd_data), 8'h09);
        step(0, 8'h00, 1, 0);
        chk("max_ack", int'(pkt_valid), 0);

        // Reset asserted mid-packet, then the full packet resent (04+01+02+03+04 = 0E, F2 closes)
        step(1, 8'hA5, 0, 0);
        step(1, 8'h04, 0, 0);
        step(1, 8'h01, 0, 0);
        chk("mid_busy", int'(busy), 1);
        #2 rst_l = 1'b0;
        #1;
        chk_idle_outputs("midrst");
        @(negedge clk);
        rx_dv = 1'b0;
        rst_l = 1'b1;
        step(1, 8'hA5, 0, 0);
        step(1, 8'h04, 0, 0);
        step(1, 8'h01, 0, 0);
        step(1, 8'h02, 0, 0);
        step(1, 8'h03, 0, 0);
        step(1, 8'h04, 0, 0);
        step(1, 8'hF2, 0, 0);
        chk("resend_valid", int'(pkt_valid), 1);
        chk("resend_len", int'(pkt_len), 4);
        step(0, 8'h00, 0, 4'd3);
        chk("resend_rd3", int'(rd_data), 8'h04);
        step(0, 8'h00, 1, 0);
        chk("resend_ack", int'(pkt_valid), 0);

`ifdef UART_PKT_TIMEOUT_EN
        begin
            int n;
            bit seen;
            n = 0;
            seen = 1'b0;
            step(1, 8'hA5, 0, 0);
            step(1, 8'h02, 0, 0);
            while (!seen && n < 200) begin
                step(0, 8'h00, 0, 0);
                n++;
                if (err_tmo) seen = 1'b1;
            end
            chk("tmo_seen", int'(seen), 1);
            chk("tmo_clks", n, TMO);
            chk("tmo_busy", int'(busy), 0);
            chk("tmo_valid", int'(pkt_valid), 0);
            step(0, 8'h00, 0, 0);
            chk("tmo_pulse_end", int'(err_tmo), 0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
